// File: rtl/btle_access_address_search_pkg.sv
// Shared constants and types for the BLE access-address search and byte packer.
// Constants only; no logic.
package btle_access_address_search_pkg;

    localparam int          AA_LEN            = 32;
    localparam logic [31:0] BTLE_ADV_AA       = 32'h8E89BED6;
    localparam int          BTLE_MAX_PDU_BYTE = 255;
    localparam int          FILL_W            = 6;

    typedef enum logic {
        ST_SEARCH  = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/btle_access_address_search_hamming.sv
// Purpose: flags when popcount(a ^ b) <= MAX_BIT_ERR, using a balanced adder tree.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
module hamming_dist_le
    import btle_access_address_search_pkg::*;
#(
    parameter int MAX_BIT_ERR = 1
) (
    input  logic [AA_LEN-1:0] a,
    input  logic [AA_LEN-1:0] b,
    output logic              le
);

    logic [AA_LEN-1:0] diff;
    logic [1:0]        l1 [16];
    logic [2:0]        l2 [8];
    logic [3:0]        l3 [4];
    logic [4:0]        l4 [2];
    logic [5:0]        pop;

    always_comb begin
        diff = a ^ b;
        for (int i = 0; i < 16; i++) l1[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
        for (int i = 0; i < 8; i++)  l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
        for (int i = 0; i < 4; i++)  l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
        for (int i = 0; i < 2; i++)  l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
        pop = {1'b0, l4[0]} + {1'b0, l4[1]};
        le  = (pop <= 6'(MAX_BIT_ERR));
    end

endmodule

// File: rtl/btle_access_address_search.sv
// Purpose: sliding-window BLE access-address search, then LSB-first byte packing of the payload.
// Latency: hit_flag / byte_valid / frame_done 1 clk after the qualifying bit_valid.
// Backpressure: none; bit_valid may be asserted every cycle, all state holds while it is low.
module btle_access_address_search
    import btle_access_address_search_pkg::*;
#(
    parameter int MAX_BIT_ERR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phy_bit,
    input  logic              bit_valid,
    input  logic [AA_LEN-1:0] access_address,
    input  logic [7:0]        num_byte,
    output logic              hit_flag,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              frame_done,
    output logic              busy
);

    // Bit 0 of both shift registers would fall out on the very shift that reads them,
    // so only the upper bits are stored.
    state_t                 state_q;
    logic [AA_LEN-1:1]      sr_q;
    logic [FILL_W-1:0]      fill_q;
    logic [7:1]             byte_sr_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             byte_cnt_q;
    logic [7:0]             nb_q;
    logic                   hit_q;
    logic                   byte_valid_q;
    logic                   frame_done_q;
    logic [7:0]             byte_out_q;

    logic [AA_LEN-1:0]      win_d;
    logic [7:0]             byte_d;
    logic                   win_le;
    logic                   hit_d;
    logic                   last_byte_d;

    assign win_d       = {phy_bit, sr_q};
    assign byte_d      = {phy_bit, byte_sr_q};
    assign hit_d       = bit_valid && (state_q == ST_SEARCH) &&
                         (fill_q >= FILL_W'(AA_LEN - 1)) && win_le;
    assign last_byte_d = ((byte_cnt_q + 8'd1) == nb_q);

    hamming_dist_le #(
        .MAX_BIT_ERR (MAX_BIT_ERR)
    ) u_hamming (
        .a  (win_d),
        .b  (access_address),
        .le (win_le)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SEARCH;
            sr_q         <= '0;
            fill_q       <= '0;
            byte_sr_q    <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            nb_q         <= '0;
            hit_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            byte_out_q   <= '0;
        end else begin
            hit_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (bit_valid) begin
                sr_q <= win_d[AA_LEN-1:1];
                if (fill_q != FILL_W'(AA_LEN)) fill_q <= fill_q + 1'b1;
                if (state_q == ST_SEARCH) begin
                    if (hit_d) begin
                        hit_q      <= 1'b1;
                        nb_q       <= num_byte;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        fill_q     <= '0;
                        if (num_byte == 8'd0) frame_done_q <= 1'b1;
                        else                  state_q      <= ST_COLLECT;
                    end
                end else begin
                    byte_sr_q <= byte_d[7:1];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_valid_q <= 1'b1;
                        byte_out_q   <= byte_d;
                        byte_cnt_q   <= byte_cnt_q + 8'd1;
                        // Window restarts empty so payload bits can never form a hit.
                        if (last_byte_d) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_SEARCH;
                            fill_q       <= '0;
                        end
                    end
                end
            end
        end
    end

    assign hit_flag   = hit_q;
    assign byte_valid = byte_valid_q;
    assign frame_done = frame_done_q;
    assign byte_out   = byte_out_q;
    assign busy       = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_btle_access_address_search.sv
// Bench for btle_access_address_search: vector table plus hand sequences, events checked via a scoreboard.
module tb_btle_access_address_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phy_bit;
    logic        bit_valid;
    logic [31:0] access_address;
    logic [7:0]  num_byte;
    logic        hit_flag;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] aa;
        logic [31:0] flip;
        logic [15:0] prefix;
        logic [7:0]  nb;
        logic [31:0] pay;
        bit          hit;
        bit          gap;
    } vec_t;

    typedef struct {
        bit         is_byte;
        logic [7:0] dat;
        bit         fd;
    } ev_t;

    vec_t vt [6];
    ev_t  sb [$];

    btle_access_address_search #(.MAX_BIT_ERR(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .phy_bit        (phy_bit),
        .bit_valid      (bit_valid),
        .access_address (access_address),
        .num_byte       (num_byte),
        .hit_flag       (hit_flag),
        .byte_out       (byte_out),
        .byte_valid     (byte_valid),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit is_byte, input logic [7:0] dat, input bit fd);
        ev_t e;
        e.is_byte = is_byte;
        e.dat     = dat;
        e.fd      = fd;
        sb.push_back(e);
    endtask

    // Sends n bits of w LSB-first; with gap, an idle cycle follows every bit but the last.
    task automatic send_bits(input logic [31:0] w, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            phy_bit   = w[i];
            bit_valid = 1'b1;
            @(negedge clk);
            if (gap && i != n - 1) begin
                bit_valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every DUT pulse must match the next queued expectation, in order.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n === 1'b1) begin
            if (hit_flag) begin
                if (sb.size() == 0) check("unexpected_hit", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("sb_hit_kind", 0, 32'(e.is_byte));
                    check("sb_hit_frame_done", 32'(frame_done), 32'(e.fd));
                end
            end
            if (byte_valid) begin
                if (sb.size() == 0) check("unexpected_byte", 32'(byte_out), 32'hFFFF);
                else begin
                    e = sb.pop_front();
                    check("sb_byte_kind", 1, 32'(e.is_byte));
                    check("sb_byte_data", 32'(byte_out), 32'(e.dat));
                    check("sb_byte_frame_done", 32'(frame_done), 32'(e.fd));
                end
            end
            if (frame_done && !hit_flag && !byte_valid) check("lone_frame_done", 1, 0);
        end
    end

    initial begin
        vt[0] = '{32'h8E89BED6, 32'h0,         16'hB4D1, 8'd2, 32'h00003CA5, 1'b1, 1'b0};
        vt[1] = '{32'h8E89BED6, 32'h00000080,  16'h2E17, 8'd1, 32'h0000005A, 1'b1, 1'b1};
        vt[2] = '{32'h8E89BED6, 32'h00100008,  16'h9C3A, 8'd1, 32'h0,        1'b0, 1'b0};
        vt[3] = '{32'h12345678, 32'h0,         16'h0000, 8'd3, 32'h00C3FF00, 1'b1, 1'b0};
        vt[4] = '{32'h8E89BED6, 32'h40000000,  16'h5555, 8'd0, 32'h0,        1'b1, 1'b0};
        vt[5] = '{32'h8E89BED6, 32'h0,         16'h1234, 8'd0, 32'h0,        1'b1, 1'b0};

        rst_n          = 1'b0;
        phy_bit        = 1'b0;
        bit_valid      = 1'b0;
        access_address = 32'h0;
        num_byte       = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_hit_flag", 32'(hit_flag), 0);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_byte_out", 32'(byte_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero AA matches the reset window: no hit until 32 bits have arrived.
        send_bits(32'h0, 31, 1'b0);
        check("no_hit_31_bits", 32'(hit_flag), 0);
        push_ev(1'b0, 8'h00, 1'b1);
        send_bits(32'h0, 1, 1'b0);
        check("hit_at_32nd_bit", 32'(hit_flag), 1);
        check("nb0_frame_done", 32'(frame_done), 1);
        check("nb0_busy", 32'(busy), 0);

        // Zero AA embedded in a zero payload must not hit; afterwards a fresh 32 bits are needed.
        num_byte = 8'd4;
        push_ev(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) push_ev(1'b1, 8'h00, k == 3);
        send_bits(32'h0, 32, 1'b0);
        check("collect_busy", 32'(busy), 1);
        send_bits(32'h0, 32, 1'b0);
        check("collect_done_busy", 32'(busy), 0);
        num_byte = 8'd0;
        send_bits(32'h0, 31, 1'b0);
        check("rearm_no_hit_31", 32'(hit_flag), 0);
        push_ev(1'b0, 8'h00, 1'b1);
        send_bits(32'h0, 1, 1'b0);
        check("rearm_hit_32", 32'(hit_flag), 1);
        idle(3);

        for (int r = 0; r < 6; r++) begin
            access_address = vt[r].aa;
            num_byte       = vt[r].nb;
            if (vt[r].hit) begin
                push_ev(1'b0, 8'h00, vt[r].nb == 8'd0);
                for (int k = 0; k < int'(vt[r].nb); k++)
                    push_ev(1'b1, vt[r].pay[8*k +: 8], k == int'(vt[r].nb) - 1);
            end
            send_bits({16'h0, vt[r].prefix}, 16, vt[r].gap);
            send_bits(vt[r].aa ^ vt[r].flip, 32, vt[r].gap);
            check($sformatf("vec%0d_hit_timing", r), 32'(hit_flag), 32'(vt[r].hit));
            check($sformatf("vec%0d_busy_after_aa", r), 32'(busy),
                  32'(vt[r].hit && vt[r].nb != 8'd0));
            if (vt[r].hit) begin
                for (int k = 0; k < int'(vt[r].nb); k++)
                    send_bits({24'h0, vt[r].pay[8*k +: 8]}, 8, vt[r].gap);
            end
            idle(2);
            check($sformatf("vec%0d_busy_end", r), 32'(busy), 0);
        end

        // Reset 12 bits into a 2-byte payload: first byte delivered, the rest must vanish.
        access_address = 32'h8E89BED6;
        num_byte       = 8'd2;
        push_ev(1'b0, 8'h00, 1'b0);
        push_ev(1'b1, 8'h6C, 1'b0);
        send_bits(32'h0F0F, 16, 1'b0);
        send_bits(32'h8E89BED6, 32, 1'b0);
        send_bits(32'h36C, 12, 1'b0);
        check("pre_reset_busy", 32'(busy), 1);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hit_flag", 32'(hit_flag), 0);
        check("mid_rst_byte_valid", 32'(byte_valid), 0);
        check("mid_rst_frame_done", 32'(frame_done), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_byte_out", 32'(byte_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(32'h00A5, 12, 1'b0);
        idle(3);
        check("post_rst_busy", 32'(busy), 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
